// File: rtl/pulse_burst_analyzer_pkg.sv
// pulse_burst_analyzer_pkg
// Shared definitions for the pulse burst analyzer: FSM state encoding and
// the default widths/timing used when the top is instantiated without
// overrides. Imported by pulse_burst_analyzer and signal_sampler.
package pulse_burst_analyzer_pkg;

    // Analyzer FSM states; encodings are fixed so waveforms and any
    // downstream decode stay stable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_COUNT_W    = 8;
    localparam int DEF_WIDTH_W    = 8;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_MIN_WIDTH  = 2;
    localparam int DEF_MAX_WIDTH  = 16;

    // Gap counter width; GAP_CYCLES never exceeds 255.
    localparam int GAP_W = 8;

endpackage

// File: rtl/pulse_burst_analyzer_signal_sampler.sv
// signal_sampler
// Front end of the analyzer: optionally synchronizes the incoming pulse
// train, keeps the previous sample and flags rising edges.
//
// Configuration macro: PULSE_SYNC_EN
//   defined   -> signal_i passes through a two-flop synchronizer (reset to 1)
//   undefined -> signal_i is used directly (must be synchronous to clock)
//
// Ports:
//   clock    in   sampling clock, posedge
//   reset    in   synchronous, active-high reset
//   signal_i in   raw pulse train
//   s_o      out  current sample used by the FSM
//   rise_o   out  s_o high while the previous sample was low
module signal_sampler
    import pulse_burst_analyzer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic signal_i,
    output logic s_o,
    output logic rise_o
);

`ifdef PULSE_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; resets high so a line already high at reset
    // release looks like a continuation rather than a fresh edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], signal_i};
        end
    end

    assign s_o = sync_q[1];
`else
    assign s_o = signal_i;
`endif

    logic sig_q;

    // Previous sample resets to 1 so a pulse in progress at reset release
    // never produces a rising edge and is therefore never counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= s_o;
        end
    end

    assign rise_o = s_o & ~sig_q;

endmodule

// File: rtl/pulse_burst_analyzer.sv
// pulse_burst_analyzer
// Groups a sampled pulse train into bursts (a burst ends after GAP_CYCLES
// consecutive low samples) and reports per-burst pulse count, the width of
// the most recent pulse and whether any pulse width was out of range.
//
// Configuration macro: PULSE_SYNC_EN (adds a 2-flop input synchronizer in
// signal_sampler; all response timing then shifts by two cycles).
//
// Ports:
//   clock        in   sampling clock, posedge
//   reset        in   synchronous, active-high reset
//   signal       in   pulse train from the upstream generator
//   busy         out  burst in progress (FSM in HIGH or LOW)
//   burst_done   out  one-cycle strobe, burst results valid
//   burst_count  out  pulses in the last completed burst
//   last_width   out  width of the most recently completed pulse
//   width_error  out  last completed burst had an out-of-range pulse
module pulse_burst_analyzer
    import pulse_burst_analyzer_pkg::*;
#(
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int WIDTH_W    = DEF_WIDTH_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               signal,
    output logic               busy,
    output logic               burst_done,
    output logic [COUNT_W-1:0] burst_count,
    output logic [WIDTH_W-1:0] last_width,
    output logic               width_error
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [WIDTH_W-1:0] WID_MAX = {WIDTH_W{1'b1}};
    localparam logic [GAP_W-1:0]   GAP_END = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WIDTH_W-1:0] WID_MIN = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] WID_LIM = WIDTH_W'(MAX_WIDTH);

    logic s;
    logic rise;

    signal_sampler u_sampler (
        .clock    (clock),
        .reset    (reset),
        .signal_i (signal),
        .s_o      (s),
        .rise_o   (rise)
    );

    state_t             state_q;
    logic [COUNT_W-1:0] pulse_cnt_q;
    logic [WIDTH_W-1:0] width_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               err_acc_q;
    logic               burst_done_q;
    logic [COUNT_W-1:0] burst_count_q;
    logic [WIDTH_W-1:0] last_width_q;
    logic               width_error_q;

    // A saturated width counter is treated as too wide even if MAX_WIDTH
    // happens to sit at the counter limit.
    logic width_bad;
    assign width_bad = (width_cnt_q < WID_MIN) || (width_cnt_q > WID_LIM) ||
                       (width_cnt_q == WID_MAX);

    // Burst FSM with all counters and result registers. DONE lasts exactly
    // one cycle; a high sample there is necessarily a rising edge (the
    // previous sample was low) and immediately opens the next burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pulse_cnt_q   <= '0;
            width_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            err_acc_q     <= 1'b0;
            burst_done_q  <= 1'b0;
            burst_count_q <= '0;
            last_width_q  <= '0;
            width_error_q <= 1'b0;
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q     <= ST_HIGH;
                        pulse_cnt_q <= COUNT_W'(1);
                        width_cnt_q <= WIDTH_W'(1);
                        err_acc_q   <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (s) begin
                        if (width_cnt_q != WID_MAX) begin
                            width_cnt_q <= width_cnt_q + WIDTH_W'(1);
                        end
                    end else begin
                        state_q      <= ST_LOW;
                        last_width_q <= width_cnt_q;
                        err_acc_q    <= err_acc_q | width_bad;
                        gap_cnt_q    <= GAP_W'(1);
                    end
                end
                ST_LOW: begin
                    if (s) begin
                        state_q     <= ST_HIGH;
                        width_cnt_q <= WIDTH_W'(1);
                        if (pulse_cnt_q != CNT_MAX) begin
                            pulse_cnt_q <= pulse_cnt_q + COUNT_W'(1);
                        end
                    end else if (gap_cnt_q == GAP_END) begin
                        state_q       <= ST_DONE;
                        burst_done_q  <= 1'b1;
                        burst_count_q <= pulse_cnt_q;
                        width_error_q <= err_acc_q;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    if (s) begin
                        state_q     <= ST_HIGH;
                        pulse_cnt_q <= COUNT_W'(1);
                        width_cnt_q <= WIDTH_W'(1);
                        err_acc_q   <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign burst_done  = burst_done_q;
    assign burst_count = burst_count_q;
    assign last_width  = last_width_q;
    assign width_error = width_error_q;

endmodule

// File: tb/tb_pulse_burst_analyzer.sv
// tb_pulse_burst_analyzer
// Directed bench for pulse_burst_analyzer (default build, PULSE_SYNC_EN
// undefined). Inputs change 1 time unit after each rising edge; outputs
// are observed at the same point, i.e. just after the edge that updated them.
module tb_pulse_burst_analyzer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       signal = 1'b0;
    logic       busy;
    logic       burst_done;
    logic [7:0] burst_count;
    logic [7:0] last_width;
    logic       width_error;

    int checks = 0;
    int failures = 0;

    // Observation state gathered while stepping
    int   strobes;
    int   strobeAt;
    int   lowIdx;
    logic busyFirst;
    logic busyAny;
    int   capCount;
    int   capWidth;
    int   capErr;

    typedef struct {
        int nPulses;
        int width;
        int gap;
        int trail;
        int expCount;
        int expWidth;
        int expErr;
    } vec_t;

    vec_t vecs[6];

    pulse_burst_analyzer dut (
        .clock       (clock),
        .reset       (reset),
        .signal      (signal),
        .busy        (busy),
        .burst_done  (burst_done),
        .burst_count (burst_count),
        .last_width  (last_width),
        .width_error (width_error)
    );

    always #5 clock = ~clock;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one sample and advance past the edge that consumes it
    task automatic applyStimulus(input logic v);
        signal = v;
        @(posedge clock);
        #1;
        busyAny = busyAny | busy;
        if (burst_done === 1'b1) begin
            strobes++;
            strobeAt = lowIdx;
            capCount = int'(burst_count);
            capWidth = int'(last_width);
            capErr   = int'(width_error);
        end
    endtask

    task automatic clearObs();
        strobes   = 0;
        strobeAt  = -1;
        lowIdx    = 0;
        busyFirst = 1'b0;
        busyAny   = 1'b0;
        capCount  = -1;
        capWidth  = -1;
        capErr    = -1;
    endtask

    // Uniform-width burst: n pulses of w highs, gap lows between pulses and
    // trail lows after the last one. lowIdx counts trailing lows (1-based).
    task automatic runBurst(input int n, input int w, input int gap, input int trail);
        for (int p = 0; p < n; p++) begin
            lowIdx = 0;
            for (int i = 0; i < w; i++) begin
                applyStimulus(1'b1);
                if (p == 0 && i == 0) busyFirst = busy;
            end
            if (p == n - 1) begin
                for (int j = 0; j < trail; j++) begin
                    lowIdx = j + 1;
                    applyStimulus(1'b0);
                end
            end else begin
                for (int j = 0; j < gap; j++) applyStimulus(1'b0);
            end
        end
        lowIdx = 0;
    endtask

    initial begin
        vecs[0] = '{2,  4, 3, 6, 2,  4, 0};
        vecs[1] = '{1,  1, 0, 6, 1,  1, 1};
        vecs[2] = '{3, 16, 2, 6, 3, 16, 0};
        vecs[3] = '{1, 17, 0, 6, 1, 17, 1};
        vecs[4] = '{2,  2, 3, 6, 2,  2, 0};
        vecs[5] = '{4,  3, 1, 6, 4,  3, 0};

        // Reset state
        clearObs();
        reset  = 1'b1;
        signal = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(burst_done), 0);
        checkOutput("reset_count", int'(burst_count), 0);
        checkOutput("reset_width", int'(last_width), 0);
        checkOutput("reset_err", int'(width_error), 0);

        // Idle low line: nothing happens
        clearObs();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0);
        checkOutput("idle_strobes", strobes, 0);
        checkOutput("idle_busy", int'(busyAny), 0);
        checkOutput("idle_count", int'(burst_count), 0);

        // Table-driven bursts
        for (int v = 0; v < 6; v++) begin
            clearObs();
            runBurst(vecs[v].nPulses, vecs[v].width, vecs[v].gap, vecs[v].trail);
            checkOutput($sformatf("v%0d_strobes", v), strobes, 1);
            checkOutput($sformatf("v%0d_strobe_at", v), strobeAt, 4);
            checkOutput($sformatf("v%0d_busy_first", v), int'(busyFirst), 1);
            checkOutput($sformatf("v%0d_count", v), capCount, vecs[v].expCount);
            checkOutput($sformatf("v%0d_width", v), capWidth, vecs[v].expWidth);
            checkOutput($sformatf("v%0d_err", v), capErr, vecs[v].expErr);
            checkOutput($sformatf("v%0d_busy_end", v), int'(busy), 0);
        end

        // Signal already high at reset release: that pulse is ignored
        clearObs();
        signal = 1'b1;
        reset  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("hr_reset_count", int'(burst_count), 0);
        checkOutput("hr_reset_width", int'(last_width), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0);
        checkOutput("hr_busy_held", int'(busyAny), 0);
        runBurst(1, 3, 0, 6);
        checkOutput("hr_strobes", strobes, 1);
        checkOutput("hr_count", capCount, 1);
        checkOutput("hr_width", capWidth, 3);
        checkOutput("hr_err", capErr, 0);

        // Pulse counter saturation
        clearObs();
        runBurst(300, 2, 2, 6);
        checkOutput("sat_strobes", strobes, 1);
        checkOutput("sat_count", capCount, 255);
        checkOutput("sat_width", capWidth, 2);
        checkOutput("sat_err", capErr, 0);

        // Reset in the gap of a burst discards it
        clearObs();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("mid_busy_pre", int'(busy), 1);
        reset = 1'b1;
        applyStimulus(1'b0);
        reset = 1'b0;
        checkOutput("mid_busy", int'(busy), 0);
        checkOutput("mid_count", int'(burst_count), 0);
        checkOutput("mid_width", int'(last_width), 0);
        checkOutput("mid_err", int'(width_error), 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0);
        checkOutput("mid_strobes", strobes, 0);
        runBurst(3, 3, 2, 6);
        checkOutput("post_strobes", strobes, 1);
        checkOutput("post_count", capCount, 3);
        checkOutput("post_width", capWidth, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
